// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner. NUM_KEYS independent debounce channels share one
// tick prescaler and report a debounced level plus press/release/long/repeat pulses.
module key_debounce_multi #(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_CYCLES    = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int TCW = $clog2(TICK_CYCLES);
  localparam int DBW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HW  = $clog2(LONG_TICKS + 1);
  localparam int RW  = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_CYCLES - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [RW-1:0]  REP_LAST  = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam logic           PIN_IDLE  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_t;

  logic [TCW-1:0]      tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] act;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TCW'(1);
    end
  end

  // Synchronisers come out of reset at the released pin level so no phantom edge appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= {NUM_KEYS{PIN_IDLE}};
      sync2 <= {NUM_KEYS{PIN_IDLE}};
    end else begin
      sync1 <= keys_in;
      sync2 <= sync1;
    end
  end

  assign act = sync2 ^ {NUM_KEYS{PIN_IDLE}};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t         state;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [RW-1:0]  rep_cnt;
    logic           state_q;
    logic           press_q;
    logic           release_q;
    logic           long_q;
    logic           repeat_q;

    // A level change always wins over a tick arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= IDLE;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          IDLE: begin
            if (act[i]) begin
              state  <= DB_PRESS;
              db_cnt <= '0;
            end
          end
          DB_PRESS: begin
            if (!act[i]) begin
              state <= IDLE;
            end else if (tick) begin
              if (db_cnt == DB_LAST) begin
                state    <= HELD;
                press_q  <= 1'b1;
                state_q  <= 1'b1;
                hold_cnt <= '0;
                rep_cnt  <= '0;
              end else begin
                db_cnt <= db_cnt + DBW'(1);
              end
            end
          end
          HELD: begin
            if (!act[i]) begin
              state  <= DB_REL;
              db_cnt <= '0;
            end else if (tick) begin
              // hold_cnt parks at LONG_TICKS; from then on the repeat counter runs.
              if (hold_cnt != HOLD_MAX) begin
                if (hold_cnt == LONG_LAST) begin
                  long_q <= 1'b1;
                end
                hold_cnt <= hold_cnt + HW'(1);
              end else if (REPEAT_TICKS > 0) begin
                if (rep_cnt == REP_LAST) begin
                  repeat_q <= 1'b1;
                  rep_cnt  <= '0;
                end else begin
                  rep_cnt <= rep_cnt + RW'(1);
                end
              end
            end
          end
          DB_REL: begin
            if (act[i]) begin
              state <= HELD;
            end else if (tick) begin
              if (db_cnt == DB_LAST) begin
                state     <= IDLE;
                release_q <= 1'b1;
                state_q   <= 1'b0;
              end else begin
                db_cnt <= db_cnt + DBW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule
